hazard_scoreboard: RTL and testbench

//  Scoreboard that sequences the ID stage of the pipelined ARM core. Tracks every in-flight

---
 rtl/hazard_scoreboard.sv | 95 +++++++++
 tb/tb_hazard_scoreboard.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: per-register countdown of in-flight writes, RAW stall
// generation for the instruction in ID, and a saturating count of stalled cycles.
module hazard_scoreboard #(
   parameter int WB_LATENCY = 2,
   parameter int NUM_REGS   = 16,
   parameter int STALL_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                issue_valid,
   input  logic                flush,
   input  logic                freeze,
   input  logic                wb_en,
   input  logic [3:0]          dest,
   input  logic [3:0]          src1,
   input  logic                src1_used,
   input  logic [3:0]          src2,
   input  logic                src2_used,
   output logic                hazard,
   output logic                issue_fire,
   output logic [NUM_REGS-1:0] pending_mask,
   output logic [STALL_W-1:0]  stall_count
);

   localparam int CW = $clog2(WB_LATENCY + 1);
   localparam logic [CW-1:0] CNT_LAT  = CW'(WB_LATENCY);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1'b1);
   localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};

   logic [CW-1:0]      cnt_q [NUM_REGS];
   logic [CW-1:0]      cnt_d [NUM_REGS];
   logic [STALL_W-1:0] stall_q;
   logic [STALL_W-1:0] stall_d;
   logic               live_s;
   logic               set_s;

   // A register is pending while its countdown is non-zero.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         pending_mask[r] = (cnt_q[r] != CNT_ZERO);
      end
   end

   // Stall is evaluated against older writers only, so a same-instruction src==dest never stalls.
   always_comb begin
      live_s     = issue_valid & ~flush;
      hazard     = live_s & ((src1_used & pending_mask[src1]) | (src2_used & pending_mask[src2]));
      issue_fire = live_s & ~hazard & ~freeze;
      set_s      = issue_fire & wb_en;
   end

   // Countdown next state: freeze holds everything, a new write re-arms to full latency.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         if (freeze) begin
            cnt_d[r] = cnt_q[r];
         end else if (set_s && (int'(dest) == r)) begin
            cnt_d[r] = CNT_LAT;
         end else if (cnt_q[r] != CNT_ZERO) begin
            cnt_d[r] = cnt_q[r] - CNT_ONE;
         end else begin
            cnt_d[r] = cnt_q[r];
         end
      end
   end

   // Saturating stall counter, not advanced while the pipeline is frozen.
   always_comb begin
      if (!freeze && hazard && (stall_q != STALL_MAX)) begin
         stall_d = stall_q + STALL_ONE;
      end else begin
         stall_d = stall_q;
      end
   end

   // State registers with synchronous reset discarding all pending entries.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= CNT_ZERO;
         end
         stall_q <= {STALL_W{1'b0}};
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
         stall_q <= stall_d;
      end
   end

   assign stall_count = stall_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (WB_LATENCY=2, STALL_W=4): RAW, independent,
// WAW re-arm, freeze, flush, R15 tracking, stall saturation and reset behaviour.
module tb_hazard_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid;
   logic        flush;
   logic        freeze;
   logic        wb_en;
   logic [3:0]  dest;
   logic [3:0]  src1;
   logic        src1_used;
   logic [3:0]  src2;
   logic        src2_used;
   logic        hazard;
   logic        issue_fire;
   logic [15:0] pending_mask;
   logic [3:0]  stall_count;

   int vectors = 0;
   int miscompares = 0;

   hazard_scoreboard #(.WB_LATENCY(2), .NUM_REGS(16), .STALL_W(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .issue_valid  (issue_valid),
      .flush        (flush),
      .freeze       (freeze),
      .wb_en        (wb_en),
      .dest         (dest),
      .src1         (src1),
      .src1_used    (src1_used),
      .src2         (src2),
      .src2_used    (src2_used),
      .hazard       (hazard),
      .issue_fire   (issue_fire),
      .pending_mask (pending_mask),
      .stall_count  (stall_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Apply the ID-stage inputs for this cycle and let combinational outputs settle.
   task automatic drive(input logic v, input logic fl, input logic fz, input logic we,
                        input logic [3:0] d, input logic [3:0] s1, input logic u1,
                        input logic [3:0] s2, input logic u2);
      issue_valid = v;
      flush       = fl;
      freeze      = fz;
      wb_en       = we;
      dest        = d;
      src1        = s1;
      src1_used   = u1;
      src2        = s2;
      src2_used   = u2;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset held two cycles while an issuing write is presented.
      rst = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 4'd0, 1'b0, 4'd0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      idle();
      chk("reset_pending", 32'(pending_mask), 32'h0000);
      chk("reset_hazard",  32'(hazard),       32'h0);
      chk("reset_stall",   32'(stall_count),  32'h0);

      // RAW: ADD R1,R1 (self-dependence, no stall), then a reader of R1.
      drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 4'd1, 1'b1, 4'd0, 1'b0);
      chk("raw_self_hazard", 32'(hazard),     32'h0);
      chk("raw_issue_fire",  32'(issue_fire), 32'h1);
      tick();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 1'b1, 4'd0, 1'b0);
      chk("raw_n1_hazard",  32'(hazard),       32'h1);
      chk("raw_n1_fire",    32'(issue_fire),   32'h0);
      chk("raw_n1_pending", 32'(pending_mask), 32'h0002);
      tick();
      chk("raw_n2_hazard",  32'(hazard),       32'h1);
      tick();
      chk("raw_n3_hazard",  32'(hazard),       32'h0);
      chk("raw_n3_fire",    32'(issue_fire),   32'h1);
      tick();
      idle();
      chk("raw_stall", 32'(stall_count), 32'h2);

      // Independent sources never stall.
      drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0, 1'b0, 4'd0, 1'b0);
      tick();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd2, 1'b1, 4'd3, 1'b1);
      chk("ind_n1_hazard",  32'(hazard),       32'h0);
      chk("ind_n1_fire",    32'(issue_fire),   32'h1);
      chk("ind_n1_pending", 32'(pending_mask), 32'h0002);
      tick();
      chk("ind_n2_hazard",  32'(hazard),       32'h0);
      tick();
      idle();
      chk("ind_n3_pending", 32'(pending_mask), 32'h0000);
      chk("ind_stall",      32'(stall_count),  32'h2);

      // WAW: R4 written at N and N+1 stays pending through N+3.
      drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd4, 4'd0, 1'b0, 4'd0, 1'b0);
      tick();
      chk("waw_n1_pending", 32'(pending_mask), 32'h0010);
      chk("waw_n1_fire",    32'(issue_fire),   32'h1);
      tick();
      idle();
      chk("waw_n2_pending", 32'(pending_mask), 32'h0010);
      tick();
      chk("waw_n3_pending", 32'(pending_mask), 32'h0010);
      tick();
      chk("waw_n4_pending", 32'(pending_mask), 32'h0000);

      // Freeze: R5 countdown and stall count hold while frozen.
      drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 4'd0, 1'b0, 4'd0, 1'b0);
      tick();
      drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd5, 1'b1);
      chk("frz_n1_hazard", 32'(hazard),     32'h1);
      chk("frz_n1_fire",   32'(issue_fire), 32'h0);
      tick();
      tick();
      chk("frz_n3_hazard",  32'(hazard),       32'h1);
      chk("frz_n3_pending", 32'(pending_mask), 32'h0020);
      tick();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd5, 1'b1);
      chk("frz_n4_stall",  32'(stall_count), 32'h2);
      chk("frz_n4_hazard", 32'(hazard),      32'h1);
      tick();
      chk("frz_n5_hazard", 32'(hazard),      32'h1);
      tick();
      chk("frz_n6_hazard", 32'(hazard),      32'h0);
      chk("frz_n6_fire",   32'(issue_fire),  32'h1);
      chk("frz_n6_stall",  32'(stall_count), 32'h4);
      tick();

      // Flush: squashed writer records nothing and masks its own hazard.
      drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd8, 4'd0, 1'b0, 4'd0, 1'b0);
      tick();
      drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd7, 4'd8, 1'b1, 4'd0, 1'b0);
      chk("fl_hazard", 32'(hazard),     32'h0);
      chk("fl_fire",   32'(issue_fire), 32'h0);
      tick();
      idle();
      chk("fl_pending", 32'(pending_mask), 32'h0100);
      chk("fl_stall",   32'(stall_count),  32'h4);
      tick();
      chk("fl_drained", 32'(pending_mask), 32'h0000);

      // Saturation: 20 hazard cycles on R15 from a cleared counter.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd15, 4'd0, 1'b0, 4'd0, 1'b0);
         tick();
         drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd15, 1'b1, 4'd0, 1'b0);
         if (i == 0) begin
            chk("r15_pending", 32'(pending_mask), 32'h8000);
         end
         tick();
         tick();
      end
      idle();
      chk("sat_stall", 32'(stall_count), 32'hF);

      // Reset mid-operation discards an in-flight write.
      drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 4'd0, 1'b0, 4'd0, 1'b0);
      tick();
      idle();
      chk("mid_pending_before", 32'(pending_mask), 32'h0004);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd2, 1'b1, 4'd0, 1'b0);
      chk("mid_pending_after", 32'(pending_mask), 32'h0000);
      chk("mid_hazard_after",  32'(hazard),       32'h0);
      chk("mid_stall_after",   32'(stall_count),  32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
